// File: rtl/store_unit_if.sv
// Request, status and data-memory signals of the store engine.
// The slave modport is the store unit; the master modport is the
// control unit / memory side that issues requests and returns read data.
interface store_unit_if;
    logic        start;
    logic [1:0]  store_type;
    logic [31:0] address;
    logic [31:0] reg_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport master (
        output start, store_type, address, reg_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, misaligned
    );

    modport slave (
        input  start, store_type, address, reg_data, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, misaligned
    );
endinterface

// File: rtl/store_unit.sv
// store_unit: executes sw/sh/sb against a word-addressed synchronous memory.
// Sub-word stores read the old word, merge the new lane in, and write it back.
// Optional feature macro: STORE_UNIT_ALIGN_CHECK_EN enables alignment checking
// and the ERR state; without it, stores are force-aligned and type 11 acts as sw.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; request captured on start
// S_READ  | old word address on mem_addr, mem_we = 0
// S_WAIT  | mem_rdata valid, latched into old_q
// S_WRITE | mem_we = 1, mem_wdata = merged word
// S_DONE  | done pulse
// S_ERR   | misaligned pulse, memory untouched (align check builds only)
module store_unit (
    input logic         clk,
    input logic         reset,
    store_unit_if.slave bus
);

    localparam logic [1:0] T_SW = 2'b00;
    localparam logic [1:0] T_SH = 2'b01;
    localparam logic [1:0] T_SB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
`ifdef STORE_UNIT_ALIGN_CHECK_EN
        S_ERR,
`endif
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] data_q, data_d;
    logic [31:0] old_q, old_d;
    logic [31:0] merged;
    logic        req_sub;
    logic        req_bad;

    assign req_sub = (bus.store_type == T_SH) || (bus.store_type == T_SB);

`ifdef STORE_UNIT_ALIGN_CHECK_EN
    assign req_bad = (bus.store_type == 2'b11)
                  || ((bus.store_type == T_SW) && (bus.address[1:0] != 2'b00))
                  || ((bus.store_type == T_SH) && bus.address[0]);
`else
    assign req_bad = 1'b0;
`endif

    // Next-state and capture logic; request registers only load in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        data_d  = data_q;
        old_d   = old_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d = bus.address;
                    type_d = bus.store_type;
                    data_d = bus.reg_data;
`ifdef STORE_UNIT_ALIGN_CHECK_EN
                    if (req_bad)
                        state_d = S_ERR;
                    else
`endif
                    if (req_sub)
                        state_d = S_READ;
                    else
                        state_d = S_WRITE;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                old_d   = bus.mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
`ifdef STORE_UNIT_ALIGN_CHECK_EN
            S_ERR:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Lane merge of the new data into the old word; anything not sh/sb is a full-word write.
    always_comb begin
        merged = data_q;
        case (type_q)
            T_SB: begin
                merged = old_q;
                case (addr_q[1:0])
                    2'd0: merged[7:0]   = data_q[7:0];
                    2'd1: merged[15:8]  = data_q[7:0];
                    2'd2: merged[23:16] = data_q[7:0];
                    default: merged[31:24] = data_q[7:0];
                endcase
            end
            T_SH: begin
                if (addr_q[1])
                    merged = {data_q[15:0], old_q[15:0]};
                else
                    merged = {old_q[31:16], data_q[15:0]};
            end
            default: merged = data_q;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            data_q  <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            data_q  <= data_d;
            old_q   <= old_d;
        end
    end

    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = merged;
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
    assign bus.misaligned = (state_q == S_ERR);
`else
    assign bus.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed cases plus random stores checked against a
// lane-mask memory model; a simple synchronous memory sits on the bus.
module tb_store_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    store_unit_if bus ();

    store_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_data;

    // Synchronous word memory: one-cycle read latency, bench preload port.
    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else if (tb_we)
            mem[tb_idx] <= tb_data;
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] t, input logic [31:0] a);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
        if (t == 2'd3) return 1'b1;
        if (t == 2'd0 && (a % 4) != 0) return 1'b1;
        if (t == 2'd1 && (a % 2) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_merge(input logic [1:0] t, input logic [31:0] a,
                                                input logic [31:0] d, input logic [31:0] old);
        int sh;
        if (t == 2'd1) begin
            sh = ((a / 2) % 2) * 16;
            return (old & ~(32'h0000FFFF << sh)) | ((d & 32'h0000FFFF) << sh);
        end
        if (t == 2'd2) begin
            sh = (a % 4) * 8;
            return (old & ~(32'h000000FF << sh)) | ((d & 32'h000000FF) << sh);
        end
        return d;
    endfunction

    task automatic poke(input int idx, input logic [31:0] d);
        tb_we   = 1'b1;
        tb_idx  = 8'(idx);
        tb_data = d;
        ref_mem[idx] = d;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic scramble_inputs();
        bus.store_type = 2'($urandom_range(0, 3));
        bus.address    = $urandom;
        bus.reg_data   = $urandom;
    endtask

    // One store from IDLE; called 1 time unit after an edge.
    task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        int          idx;
        int          we_cyc, done_cyc, mis_cyc, we_cnt, busy_cnt, both;
        int          e_we, e_done, e_mis, e_busy, e_we_cnt;
        logic        exp_mis;
        logic [31:0] old_word, exp_word, w_addr, w_data;
        idx      = int'(a[9:2]);
        old_word = ref_mem[idx];
        exp_mis  = model_mis(t, a);
        exp_word = exp_mis ? old_word : model_merge(t, a, d, old_word);
        we_cyc = -1; done_cyc = -1; mis_cyc = -1;
        we_cnt = 0; busy_cnt = 0; both = 0;
        w_addr = '0; w_data = '0;
        bus.start      = 1'b1;
        bus.store_type = t;
        bus.address    = a;
        bus.reg_data   = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= 10; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.mem_we) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = k;
                    w_addr = bus.mem_addr;
                    w_data = bus.mem_wdata;
                end
            end
            if (bus.done && done_cyc < 0) done_cyc = k;
            if (bus.misaligned && mis_cyc < 0) mis_cyc = k;
            if (bus.done && bus.misaligned) both++;
            @(posedge clk);
            #1;
        end
        if (exp_mis) begin
            e_we = -1; e_done = -1; e_mis = 1; e_busy = 1; e_we_cnt = 0;
        end else if (t == 2'd1 || t == 2'd2) begin
            e_we = 3; e_done = 4; e_mis = -1; e_busy = 4; e_we_cnt = 1;
        end else begin
            e_we = 1; e_done = 2; e_mis = -1; e_busy = 2; e_we_cnt = 1;
        end
        chk("we_cycle", 32'(we_cyc), 32'(e_we));
        chk("we_count", 32'(we_cnt), 32'(e_we_cnt));
        chk("done_cycle", 32'(done_cyc), 32'(e_done));
        chk("mis_cycle", 32'(mis_cyc), 32'(e_mis));
        chk("busy_cycles", 32'(busy_cnt), 32'(e_busy));
        chk("done_and_mis", 32'(both), 32'd0);
        if (!exp_mis) begin
            chk("wr_addr", w_addr, a & 32'hFFFF_FFFC);
            chk("wr_data", w_data, exp_word);
        end
        chk("mem_word", mem[idx], exp_word);
        ref_mem[idx] = exp_word;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_mis"}, 32'(bus.misaligned), 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        int          we_seen;
        int          we_c1, we_c2, dn_c1, dn_c2, busy5;
        logic [31:0] w1, w2;
        total = 0;
        bad   = 0;
        tb_we = 1'b0; tb_idx = '0; tb_data = '0;
        bus.start = 1'b0; bus.store_type = '0; bus.address = '0; bus.reg_data = '0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        do_store(2'd0, 32'h200, 32'h89ABCDEF);
        chk("sw_const", mem[8'h80], 32'h89ABCDEF);
        poke(8'h40, 32'hDEADBEEF);
        do_store(2'd2, 32'h103, 32'h123456AB);
        chk("sb_const", mem[8'h40], 32'hABADBEEF);
        poke(8'h40, 32'h11223344);
        do_store(2'd1, 32'h102, 32'h0000CAFE);
        chk("sh_hi_const", mem[8'h40], 32'hCAFE3344);
        poke(8'h40, 32'h11223344);
        do_store(2'd1, 32'h100, 32'h0000CAFE);
        chk("sh_lo_const", mem[8'h40], 32'h1122CAFE);
        poke(8'h40, 32'h11223344);
        do_store(2'd1, 32'h101, 32'h0000CAFE);
        do_store(2'd0, 32'h102, 32'h5A5A5A5A);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
        chk("mis_untouched", mem[8'h40], 32'h11223344);
`else
        chk("force_aligned", mem[8'h40], 32'h5A5A5A5A);
`endif

        // Reset during WAIT of an sb.
        poke(8'h40, 32'hCAFEF00D);
        bus.start = 1'b1; bus.store_type = 2'd2; bus.address = 32'h101; bus.reg_data = 32'h77;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        we_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_we) we_seen++;
        end
        chk("midrst_no_we", 32'(we_seen), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_mem", mem[8'h40], 32'hCAFEF00D);
        do_store(2'd0, 32'h104, 32'h0BADCAFE);

        // start held high across an sb; second request (sw) waits for IDLE.
        w1 = model_merge(2'd2, 32'h10A, 32'hA5, ref_mem[8'h42]);
        w2 = 32'h13579BDF;
        we_c1 = -1; we_c2 = -1; dn_c1 = -1; dn_c2 = -1; busy5 = -1;
        bus.start = 1'b1; bus.store_type = 2'd2; bus.address = 32'h10A; bus.reg_data = 32'hA5;
        @(posedge clk);
        #1;
        bus.store_type = 2'd0; bus.address = 32'h204; bus.reg_data = w2;
        for (int k = 1; k <= 10; k++) begin
            if (bus.mem_we) begin
                if (we_c1 < 0) we_c1 = k; else if (we_c2 < 0) we_c2 = k;
            end
            if (bus.done) begin
                if (dn_c1 < 0) dn_c1 = k; else if (dn_c2 < 0) dn_c2 = k;
            end
            if (k == 5) busy5 = int'(bus.busy);
            if (k == 6) bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("hold_we1", 32'(we_c1), 32'd3);
        chk("hold_done1", 32'(dn_c1), 32'd4);
        chk("hold_idle5", 32'(busy5), 32'd0);
        chk("hold_we2", 32'(we_c2), 32'd6);
        chk("hold_done2", 32'(dn_c2), 32'd7);
        chk("hold_mem1", mem[8'h42], w1);
        chk("hold_mem2", mem[8'h81], w2);
        ref_mem[8'h42] = w1;
        ref_mem[8'h81] = w2;

        // Random stores against the model.
        for (int n = 0; n < 40; n++) begin
            do_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 1023)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
